// File: rtl/arm_pkg.sv
// Shared definitions for the ARMv4 store-multiple sequencer.
//   - FSM state encodings (IDLE / XFER / DONE)
//   - addressing-mode encodings, indexed as {mode_u, mode_p}
//   - architectural constants (PC register index, bytes per word)
//   - popcount16: number of set bits in a 16-bit register list
package arm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_DB = 2'b01;
    localparam logic [1:0] MODE_IA = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam int         WORD_BYTES = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lsb_finder.sv
// Lowest-set-bit priority encoder.
// Ports:
//   vec   in  16  bit vector to search
//   idx   out 4   index of the lowest set bit (0 when vec is zero)
//   valid out 1   vec has at least one bit set
module lsb_finder (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/stm_sequencer.sv
// Store-multiple sequencer: walks a 16-bit register list lowest-first,
// reads each register through one bank read port and emits one memory
// write beat per register, lowest register at the lowest address.
// Optional feature macro: STM_WRITEBACK_EN (base-register writeback port).
// Ports:
//   CLK, rst                 clock, synchronous active-high reset
//   start, reg_list, base,
//   mode_u, mode_p           request; sampled only while idle
//   base_reg                 writeback target register (STM_WRITEBACK_EN)
//   rd_addr / rd_data        bank read port (combinational read)
//   mem_we, mem_addr,
//   mem_wdata / mem_ready    write beat, accepted when mem_we & mem_ready
//   wb_we, wb_addr, wb_data  base writeback pulse (STM_WRITEBACK_EN)
//   busy, done               status
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; list, base and mode sampled here
// XFER    | one register issued per free output slot until list empty
// DONE    | one-cycle completion pulse (and writeback), then IDLE
module stm_sequencer
    import arm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base,
    input  logic              mode_u,
    input  logic              mode_p,
    output logic [3:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
`ifdef STM_WRITEBACK_EN
    input  logic [3:0]        base_reg,
    output logic              wb_we,
    output logic [3:0]        wb_addr,
    output logic [ADDR_W-1:0] wb_data,
`endif
    output logic              busy,
    output logic              done
);

    logic [1:0]        state_q, state_d;
    logic [15:0]       pending_q, pending_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [3:0]        lsb_idx;
    logic              lsb_valid;
    logic [15:0]       clr_mask;
    logic              slot_free;
    logic [ADDR_W-1:0] four_n;
    logic [ADDR_W-1:0] start_addr;

    lsb_finder u_lsb (
        .vec   (pending_q),
        .idx   (lsb_idx),
        .valid (lsb_valid)
    );

    assign clr_mask  = 16'd1 << lsb_idx;
    assign slot_free = !mem_we_q || mem_ready;
    assign four_n    = ADDR_W'(popcount16(reg_list)) << 2;

    // Lowest register always lands at the lowest address, so decrementing
    // modes start at the bottom of the block and still count upward.
    always_comb begin
        start_addr = base;
        case ({mode_u, mode_p})
            MODE_IA: start_addr = base;
            MODE_IB: start_addr = base + ADDR_W'(WORD_BYTES);
            MODE_DA: start_addr = base - four_n + ADDR_W'(WORD_BYTES);
            MODE_DB: start_addr = base - four_n;
            default: start_addr = base;
        endcase
    end

`ifdef STM_WRITEBACK_EN
    logic [3:0]        wb_addr_q, wb_addr_d;
    logic [ADDR_W-1:0] wb_data_q, wb_data_d;

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (state_q == ST_IDLE && start) begin
            wb_addr_d = base_reg;
            wb_data_d = mode_u ? (base + four_n) : (base - four_n);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we   = (state_q == ST_DONE);
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
`endif

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cur_addr_d  = cur_addr_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pending_d  = reg_list;
                    cur_addr_d = start_addr;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (slot_free) begin
                    if (lsb_valid) begin
                        mem_wdata_d = rd_data;
                        mem_addr_d  = cur_addr_q;
                        mem_we_d    = 1'b1;
                        pending_d   = pending_q & ~clr_mask;
                        cur_addr_d  = cur_addr_q + ADDR_W'(WORD_BYTES);
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            cur_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_addr_q  <= cur_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rd_addr   = (state_q == ST_XFER) ? lsb_idx : 4'd0;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule
